exec_unit_mc: RTL and testbench
===============================

// Module: exec_unit_mc
// PURPOSE
//  Multi-cycle RV32I/RV64I+M execute stage. Accepts one decoded op per valid/ready handshake.
//  Produces result and branch outcome through a registered, back-pressurable output.
//  Single-cycle ALU/branch/jump ops complete in 1 cycle. MUL*/DIV*/REM* run iteratively.
//  Sits between the decode/regfile-read stage and memory/writeback.
// PARAMETERS
//  WIDTH            32  datapath width; legal values 32, 64
//  INSTR_TYPE_WIDTH 8   width of the instr_type code
//  MUL_STEP         2   multiplier bits retired per cycle; 1, 2 or 4; must divide WIDTH
//  TAG_WIDTH        5   opaque tag (rd index) carried from input to output
// PORTS
//  clk        in   1                 clock, rising edge
//  reset      in   1                 synchronous, active-high
//  flush      in   1                 synchronous kill of the in-flight op
//  in_valid   in   1                 op present on the in_* bus
//  in_ready   out  1                 unit can accept an op this cycle
//  instr_type in   INSTR_TYPE_WIDTH  op code from exec_pkg
//  pc         in   WIDTH             program counter of the op
//  rs1        in   WIDTH             operand 1
//  rs2        in   WIDTH             operand 2
//  imm        in   WIDTH             sign-extended immediate
//  in_tag     in   TAG_WIDTH         destination tag
//  out_valid  out  1                 result valid
//  out_ready  in   1                 consumer accepts the result
//  result     out  WIDTH             ALU result, address, or link/target
//  is_taken   out  1                 branch/jump taken
//  out_tag    out  TAG_WIDTH         tag of the result
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, result=0, is_taken=0, out_tag=0, step counter=0.
//  - FSM: IDLE, BUSY, DONE.
//  - in_ready = (IDLE) | (DONE & out_ready). An op is accepted when in_valid & in_ready.
//  - Single-cycle ops (ALU, LUI, AUIPC, JAL, JALR, LOAD addr, branches):
//    - Accept -> DONE. out_valid is high the next cycle.
//    - Back-to-back ops sustain 1 op/cycle while out_ready=1.
//  - MUL/MULH/MULHSU/MULHU: accept -> BUSY for WIDTH/MUL_STEP cycles -> DONE.
//    - Operands are made unsigned with recorded signs; the 2*WIDTH product is negated if the signs differ.
//    - MUL returns the low WIDTH bits. MULH* return the high WIDTH bits.
//  - DIV/DIVU/REM/REMU: restoring division, one quotient bit per cycle.
//    - WIDTH cycles in BUSY, plus 1 sign-fixup cycle, then DONE.
//    - Remainder takes the sign of the dividend.
//  - Special cases complete in 1 cycle, like ALU ops:
//    - Divide by zero: quotient = all ones; remainder = rs1.
//    - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
//  - DONE & !out_ready: all outputs hold stable and in_ready=0.
//  - DONE & out_ready & !in_valid: -> IDLE and out_valid=0.
//  - Signed compares (SLT, SLTI, BLT, BGE) use true two's-complement.
//    - Example: BLT with -1 vs 1 is taken.
//  - Shift amount is imm/rs2[4:0] for WIDTH=32 and [5:0] for WIDTH=64. SRA/SRAI are arithmetic.
//  - JAL/JALR:
//    - result = pc+imm and (rs1+imm)&~1 respectively.
//    - is_taken=1; link address is computed downstream.
//  - Branches: result = pc+imm; is_taken = condition.
//  - Non-taken and non-control ops drive is_taken=0.
//  - Unknown instr_type: result=0, is_taken=0, 1-cycle completion (no hang).
//  - flush (priority over accept):
//    - Next cycle: state=IDLE and out_valid=0. The in-flight or held result is dropped.
//    - An op presented with flush=1 is not accepted.
//  - Reset mid-BUSY has the same effect as at power-up. The partial product/quotient is discarded.
//  - Within a cycle, reset has priority over flush, and flush over the handshake.
// STRUCTURE
//  - exec_pkg:
//    - instr_type codes (IS_* incl. IS_MUL, IS_MULH, IS_MULHSU, IS_MULHU, IS_DIV, IS_DIVU, IS_REM, IS_REMU).
//    - FSM state enum.
//    - Helper function is_multicycle(code).
//  - Sub-module muldiv_iter:
//    - Iterative mul/div datapath with start/busy/done.
//    - Same WIDTH and MUL_STEP parameters.
//    - Owns the step counter and sign fixup.
//  - Top: handshake FSM, single-cycle ALU, output register.
// TESTING
//  1. ADDI rs1=5, imm=-3, out_ready=1: out_valid next cycle, result=2.
//     Follow with 4 back-to-back ADDs: 4 results on 4 consecutive cycles.
//  2. MUL rs1=-7, rs2=6, WIDTH=32, MUL_STEP=2: out_valid 17 cycles after accept, result=0xFFFFFFD6.
//     MULHU 0xFFFFFFFF x 2 -> result=1.
//  3. DIV rs1=-20, rs2=3: quotient -6 (0xFFFFFFFA), out_valid at cycle 34.
//     REM -> -2. DIVU x/0 -> 0xFFFFFFFF. DIV 0x80000000/-1 -> 0x80000000 in 1 cycle.
//  4. BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20: is_taken=1, result=0x120.
//     BGEU same operands -> is_taken=1.
//  5. DIV accepted, flush at cycle 10: no out_valid; in_ready=1 the next cycle.
//     A new ADD then completes normally. Repeat the sequence with reset instead of flush.
//  6. ADD completes with out_ready=0 for 3 cycles: result and out_tag stable, in_ready=0.
//     Release out_ready: one transfer only.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the multi-cycle execute stage.
//   - op_t / IS_* : instr_type codes driven by decode
//   - state_e     : handshake FSM states
//   - is_multicycle(), is_div() : op-class helpers
package exec_pkg;

  typedef logic [7:0] op_t;

  // Register-register ALU
  localparam op_t IS_ADD    = 8'h00;
  localparam op_t IS_SUB    = 8'h01;
  localparam op_t IS_AND    = 8'h02;
  localparam op_t IS_OR     = 8'h03;
  localparam op_t IS_XOR    = 8'h04;
  localparam op_t IS_SLL    = 8'h05;
  localparam op_t IS_SRL    = 8'h06;
  localparam op_t IS_SRA    = 8'h07;
  localparam op_t IS_SLT    = 8'h08;
  localparam op_t IS_SLTU   = 8'h09;
  // Register-immediate ALU
  localparam op_t IS_ADDI   = 8'h10;
  localparam op_t IS_ANDI   = 8'h11;
  localparam op_t IS_ORI    = 8'h12;
  localparam op_t IS_XORI   = 8'h13;
  localparam op_t IS_SLLI   = 8'h14;
  localparam op_t IS_SRLI   = 8'h15;
  localparam op_t IS_SRAI   = 8'h16;
  localparam op_t IS_SLTI   = 8'h17;
  localparam op_t IS_SLTIU  = 8'h18;
  // Upper-immediate, jumps, load address
  localparam op_t IS_LUI    = 8'h20;
  localparam op_t IS_AUIPC  = 8'h21;
  localparam op_t IS_JAL    = 8'h22;
  localparam op_t IS_JALR   = 8'h23;
  localparam op_t IS_LOAD   = 8'h24;
  // Conditional branches
  localparam op_t IS_BEQ    = 8'h30;
  localparam op_t IS_BNE    = 8'h31;
  localparam op_t IS_BLT    = 8'h32;
  localparam op_t IS_BGE    = 8'h33;
  localparam op_t IS_BLTU   = 8'h34;
  localparam op_t IS_BGEU   = 8'h35;
  // M extension
  localparam op_t IS_MUL    = 8'h40;
  localparam op_t IS_MULH   = 8'h41;
  localparam op_t IS_MULHSU = 8'h42;
  localparam op_t IS_MULHU  = 8'h43;
  localparam op_t IS_DIV    = 8'h44;
  localparam op_t IS_DIVU   = 8'h45;
  localparam op_t IS_REM    = 8'h46;
  localparam op_t IS_REMU   = 8'h47;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic logic is_div(op_t code);
    return code inside {IS_DIV, IS_DIVU, IS_REM, IS_REMU};
  endfunction

  function automatic logic is_multicycle(op_t code);
    return is_div(code) || (code inside {IS_MUL, IS_MULH, IS_MULHSU, IS_MULHU});
  endfunction

endpackage

// File: rtl/exec_unit_mc_if.sv
// Op-in / result-out handshake bus of the execute stage.
//   in_*    : decoded op from regfile-read (valid/ready)
//   out_*   : registered result to memory/writeback (valid/ready)
// master = producer of ops / consumer of results, slave = execute unit.
interface exec_unit_mc_if #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned INSTR_TYPE_WIDTH = 8,
  parameter int unsigned TAG_WIDTH        = 5
) ();
  logic                        in_valid;
  logic                        in_ready;
  logic [INSTR_TYPE_WIDTH-1:0] instr_type;
  logic [WIDTH-1:0]            pc;
  logic [WIDTH-1:0]            rs1;
  logic [WIDTH-1:0]            rs2;
  logic [WIDTH-1:0]            imm;
  logic [TAG_WIDTH-1:0]        in_tag;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            result;
  logic                        is_taken;
  logic [TAG_WIDTH-1:0]        out_tag;

  modport master (
    output in_valid, instr_type, pc, rs1, rs2, imm, in_tag, out_ready,
    input  in_ready, out_valid, result, is_taken, out_tag
  );

  modport slave (
    input  in_valid, instr_type, pc, rs1, rs2, imm, in_tag, out_ready,
    output in_ready, out_valid, result, is_taken, out_tag
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply / restoring-divide datapath.
//   clk, reset : clock, synchronous active-high reset
//   flush      : abandon the op in progress
//   start      : load operands (a, b) and op; ignored while busy
//   busy       : op in progress
//   done       : one-cycle pulse, result valid in this same cycle
//   result     : MUL low / MULH* high half, quotient or remainder
// Multiply takes WIDTH/MUL_STEP cycles; divide takes WIDTH cycles plus one sign-fixup cycle.
module muldiv_iter import exec_pkg::*; #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int unsigned MulSteps = WIDTH / MUL_STEP;
  localparam int unsigned CntW     = $clog2(WIDTH + 1);
  localparam int unsigned W2       = 2 * WIDTH;

  logic            busy_q, busy_d, is_div_q, is_div_d, sel_hi_q, sel_hi_d;
  logic            want_rem_q, want_rem_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Multiply: acc = running product. Divide: acc = {partial remainder, dividend/quotient}.
  logic [W2-1:0]    acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] opb_q, opb_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [W2-1:0]    mul_sum, acc_mul, prod_fix, acc_div;
  logic [WIDTH:0]   rem_sh, diff;
  logic             div_ge;

  assign a_neg = a[WIDTH-1] && (op inside {IS_MUL, IS_MULH, IS_MULHSU, IS_DIV, IS_REM});
  assign b_neg = b[WIDTH-1] && (op inside {IS_MUL, IS_MULH, IS_DIV, IS_REM});
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  always_comb begin
    mul_sum = '0;
    for (int i = 0; i < int'(MUL_STEP); i++) begin
      if (opb_q[i]) mul_sum = mul_sum + (mcand_q << i);
    end
    acc_mul  = acc_q + mul_sum;
    prod_fix = neg_q ? -acc_mul : acc_mul;
    // Restoring step: the sign of the trial subtraction is the inverted quotient bit.
    rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, opb_q};
    div_ge   = !diff[WIDTH];
    acc_div  = {(div_ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
  end

  assign busy = busy_q;
  assign done = busy_q && (is_div_q ? (cnt_q == CntW'(WIDTH)) : (cnt_q == CntW'(MulSteps - 1)));

  always_comb begin
    if (is_div_q) begin
      if (want_rem_q) result = rem_neg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
      else            result = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end else begin
      result = sel_hi_q ? prod_fix[W2-1:WIDTH] : prod_fix[WIDTH-1:0];
    end
  end

  always_comb begin
    busy_d = busy_q;  is_div_d = is_div_q;  sel_hi_d = sel_hi_q;  want_rem_d = want_rem_q;
    neg_d = neg_q;    rem_neg_d = rem_neg_q; cnt_d = cnt_q;
    acc_d = acc_q;    mcand_d = mcand_q;    opb_d = opb_q;
    if (flush) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start && !busy_q) begin
      busy_d     = 1'b1;
      cnt_d      = '0;
      is_div_d   = is_div(op);
      sel_hi_d   = (op != IS_MUL);
      want_rem_d = op inside {IS_REM, IS_REMU};
      neg_d      = a_neg ^ b_neg;
      rem_neg_d  = a_neg;
      opb_d      = abs_b;
      mcand_d    = {{WIDTH{1'b0}}, abs_a};
      acc_d      = is_div(op) ? {{WIDTH{1'b0}}, abs_a} : '0;
    end else if (busy_q) begin
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (is_div_q) begin
        if (cnt_q != CntW'(WIDTH)) acc_d = acc_div;  // last cycle is sign fixup only
      end else begin
        acc_d   = acc_mul;
        mcand_d = mcand_q << MUL_STEP;
        opb_d   = opb_q >> MUL_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;  is_div_q <= 1'b0;  sel_hi_q <= 1'b0;  want_rem_q <= 1'b0;
      neg_q  <= 1'b0;  rem_neg_q <= 1'b0; cnt_q <= '0;
      acc_q  <= '0;    mcand_q <= '0;     opb_q <= '0;
    end else begin
      busy_q <= busy_d;  is_div_q <= is_div_d;   sel_hi_q <= sel_hi_d;  want_rem_q <= want_rem_d;
      neg_q  <= neg_d;   rem_neg_q <= rem_neg_d; cnt_q <= cnt_d;
      acc_q  <= acc_d;   mcand_q <= mcand_d;     opb_q <= opb_d;
    end
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle RV32I/RV64I+M execute stage.
//   clk, reset : clock, synchronous active-high reset
//   flush      : kill the in-flight or held op; blocks accept this cycle
//   bus        : exec_unit_mc_if slave - op in (valid/ready), registered result out (valid/ready)
// Single-cycle ops go straight to DONE; MUL*/DIV*/REM* run in muldiv_iter except the
// divide-by-zero and MIN/-1 cases, which the ALU resolves in one cycle.
module exec_unit_mc import exec_pkg::*; #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned INSTR_TYPE_WIDTH = 8,
  parameter int unsigned MUL_STEP         = 2,
  parameter int unsigned TAG_WIDTH        = 5
) (
  input logic           clk,
  input logic           reset,
  input logic           flush,
  exec_unit_mc_if.slave bus
);
  localparam int unsigned ShW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d, alu_res, rs1, rs2, imm, pc, jalr_sum;
  logic                 taken_q, taken_d, alu_taken;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [INSTR_TYPE_WIDTH-1:0] code_raw;
  op_t                  code;
  logic                 in_ready, accept, div_zero, div_ovf, div_special, go_multi;
  logic                 md_busy, md_done;
  logic [WIDTH-1:0]     md_result;

  assign code_raw = bus.instr_type;
  assign code     = op_t'(code_raw);
  assign rs1      = bus.rs1;
  assign rs2      = bus.rs2;
  assign imm      = bus.imm;
  assign pc       = bus.pc;
  assign jalr_sum = rs1 + imm;

  assign div_zero    = (rs2 == '0);
  assign div_ovf     = (rs1 == MinVal) && (rs2 == '1);
  assign div_special = is_div(code) &&
                       (div_zero || (div_ovf && (code inside {IS_DIV, IS_REM})));
  assign go_multi    = is_multicycle(code) && !div_special;

  always_comb begin
    alu_res   = '0;
    alu_taken = 1'b0;
    case (code)
      IS_ADD:   alu_res = rs1 + rs2;
      IS_SUB:   alu_res = rs1 - rs2;
      IS_AND:   alu_res = rs1 & rs2;
      IS_OR:    alu_res = rs1 | rs2;
      IS_XOR:   alu_res = rs1 ^ rs2;
      IS_SLL:   alu_res = rs1 << rs2[ShW-1:0];
      IS_SRL:   alu_res = rs1 >> rs2[ShW-1:0];
      IS_SRA:   alu_res = $signed(rs1) >>> rs2[ShW-1:0];
      IS_SLT:   alu_res = WIDTH'($signed(rs1) < $signed(rs2));
      IS_SLTU:  alu_res = WIDTH'(rs1 < rs2);
      IS_ADDI:  alu_res = rs1 + imm;
      IS_ANDI:  alu_res = rs1 & imm;
      IS_ORI:   alu_res = rs1 | imm;
      IS_XORI:  alu_res = rs1 ^ imm;
      IS_SLLI:  alu_res = rs1 << imm[ShW-1:0];
      IS_SRLI:  alu_res = rs1 >> imm[ShW-1:0];
      IS_SRAI:  alu_res = $signed(rs1) >>> imm[ShW-1:0];
      IS_SLTI:  alu_res = WIDTH'($signed(rs1) < $signed(imm));
      IS_SLTIU: alu_res = WIDTH'(rs1 < imm);
      IS_LUI:   alu_res = imm;
      IS_AUIPC: alu_res = pc + imm;
      IS_LOAD:  alu_res = jalr_sum;
      IS_JAL:  begin alu_res = pc + imm;                    alu_taken = 1'b1; end
      IS_JALR: begin alu_res = {jalr_sum[WIDTH-1:1], 1'b0}; alu_taken = 1'b1; end
      IS_BEQ:  begin alu_res = pc + imm; alu_taken = (rs1 == rs2); end
      IS_BNE:  begin alu_res = pc + imm; alu_taken = (rs1 != rs2); end
      IS_BLT:  begin alu_res = pc + imm; alu_taken = ($signed(rs1) < $signed(rs2)); end
      IS_BGE:  begin alu_res = pc + imm; alu_taken = ($signed(rs1) >= $signed(rs2)); end
      IS_BLTU: begin alu_res = pc + imm; alu_taken = (rs1 < rs2); end
      IS_BGEU: begin alu_res = pc + imm; alu_taken = (rs1 >= rs2); end
      // Only reached for the one-cycle special cases; normal ones go to muldiv_iter.
      IS_DIV:   alu_res = div_zero ? '1 : MinVal;
      IS_DIVU:  alu_res = '1;
      IS_REM:   alu_res = div_zero ? rs1 : '0;
      IS_REMU:  alu_res = rs1;
      default:  alu_res = '0;
    endcase
  end

  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready && !flush;

  muldiv_iter #(
    .WIDTH    (WIDTH),
    .MUL_STEP (MUL_STEP)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .start  (accept && go_multi),
    .op     (code),
    .a      (rs1),
    .b      (rs2),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    taken_d  = taken_q;
    tag_d    = tag_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            tag_d = bus.in_tag;
            if (go_multi) begin
              state_d = StBusy;
            end else begin
              state_d  = StDone;
              result_d = alu_res;
              taken_d  = alu_taken;
            end
          end else if (state_q == StDone && bus.out_ready) begin
            state_d = StIdle;
          end
        end
        StBusy: begin
          if (md_done) begin
            state_d  = StDone;
            result_d = md_result;
            taken_d  = 1'b0;
          end else if (!md_busy) begin
            state_d = StIdle;  // datapath lost its op; never wait forever
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      taken_q  <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      taken_q  <= taken_d;
      tag_q    <= tag_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.is_taken  = taken_q;
  assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc (WIDTH=32, MUL_STEP=2): latency, results, branch outcome,
// back-pressure, flush and reset-abort, with hand-computed expectations.
module tb_exec_unit_mc;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  exec_unit_mc_if #(.WIDTH(32), .INSTR_TYPE_WIDTH(8), .TAG_WIDTH(5)) bus ();

  exec_unit_mc #(
    .WIDTH            (32),
    .INSTR_TYPE_WIDTH (8),
    .MUL_STEP         (2),
    .TAG_WIDTH        (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input op_t op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] p, input logic [31:0] im, input logic [4:0] tg);
    bus.in_valid   = 1'b1;
    bus.instr_type = op;
    bus.rs1        = r1;
    bus.rs2        = r2;
    bus.pc         = p;
    bus.imm        = im;
    bus.in_tag     = tg;
  endtask

  // Issue from IDLE; lat = cycles from accept to out_valid (-1 on timeout).
  task automatic run_op(input op_t op, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] p, input logic [31:0] im, input logic [4:0] tg,
                        output int lat);
    drive(op, r1, r2, p, im, tg);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    bus.in_valid = 1'b0; bus.instr_type = '0; bus.pc = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.imm = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;

    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result",    bus.result, 0);
    check("rst_is_taken",  bus.is_taken, 0);
    check("rst_out_tag",   bus.out_tag, 0);
    check("rst_in_ready",  bus.in_ready, 1);

    // ADDI then four back-to-back ADDs, one result per cycle
    drive(IS_ADDI, 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFD, 5'd1);
    tick();
    check("addi_valid", bus.out_valid, 1);
    check("addi_result", bus.result, 32'd2);
    check("addi_tag", bus.out_tag, 1);
    for (int i = 0; i < 4; i++) begin
      drive(IS_ADD, 32'(100 + i), 32'(3 * i), 32'd0, 32'd0, 5'(i + 2));
      tick();
      check("b2b_valid", bus.out_valid, 1);
      check("b2b_result", bus.result, 64'(100 + 4 * i));
      check("b2b_tag", bus.out_tag, 64'(i + 2));
    end
    bus.in_valid = 1'b0;
    tick();
    check("b2b_drain", bus.out_valid, 0);

    // Multiply
    run_op(IS_MUL, 32'hFFFF_FFF9, 32'd6, 32'd0, 32'd0, 5'd3, lat);
    check("mul_latency", lat, 17);
    check("mul_result", bus.result, 32'hFFFF_FFD6);
    check("mul_tag", bus.out_tag, 3);
    tick();
    run_op(IS_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd4, lat);
    check("mulhu_latency", lat, 17);
    check("mulhu_result", bus.result, 32'd1);
    tick();
    run_op(IS_MULH, 32'hFFFF_FFF9, 32'd6, 32'd0, 32'd0, 5'd4, lat);
    check("mulh_result", bus.result, 32'hFFFF_FFFF);
    tick();

    // Divide and remainder, including the one-cycle special cases
    run_op(IS_DIV, 32'hFFFF_FFEC, 32'd3, 32'd0, 32'd0, 5'd5, lat);
    check("div_latency", lat, 34);
    check("div_result", bus.result, 32'hFFFF_FFFA);
    tick();
    run_op(IS_REM, 32'hFFFF_FFEC, 32'd3, 32'd0, 32'd0, 5'd6, lat);
    check("rem_latency", lat, 34);
    check("rem_result", bus.result, 32'hFFFF_FFFE);
    tick();
    run_op(IS_DIVU, 32'd1234, 32'd0, 32'd0, 32'd0, 5'd7, lat);
    check("divu0_latency", lat, 1);
    check("divu0_result", bus.result, 32'hFFFF_FFFF);
    tick();
    run_op(IS_REM, 32'd1234, 32'd0, 32'd0, 32'd0, 5'd7, lat);
    check("rem0_result", bus.result, 32'd1234);
    tick();
    run_op(IS_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd8, lat);
    check("divovf_latency", lat, 1);
    check("divovf_result", bus.result, 32'h8000_0000);
    tick();
    run_op(IS_REMU, 32'd20, 32'd3, 32'd0, 32'd0, 5'd8, lat);
    check("remu_result", bus.result, 32'd2);
    tick();

    // Branches, jumps, shifts, compares
    run_op(IS_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd9, lat);
    check("blt_taken", bus.is_taken, 1);
    check("blt_result", bus.result, 32'h120);
    tick();
    run_op(IS_BGEU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd9, lat);
    check("bgeu_taken", bus.is_taken, 1);
    tick();
    run_op(IS_BEQ, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd9, lat);
    check("beq_not_taken", bus.is_taken, 0);
    tick();
    run_op(IS_JALR, 32'h1001, 32'd0, 32'h0, 32'd2, 5'd10, lat);
    check("jalr_result", bus.result, 32'h1002);
    check("jalr_taken", bus.is_taken, 1);
    tick();
    run_op(IS_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd11, lat);
    check("sra_result", bus.result, 32'hF800_0000);
    check("sra_not_taken", bus.is_taken, 0);
    tick();
    run_op(IS_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd11, lat);
    check("slt_result", bus.result, 32'd1);
    tick();
    run_op(8'hFF, 32'd7, 32'd9, 32'h40, 32'h4, 5'd12, lat);
    check("unknown_latency", lat, 1);
    check("unknown_result", bus.result, 0);
    tick();

    // Flush kills a running divide
    drive(IS_DIV, 32'hFFFF_FFEC, 32'd3, 32'd0, 32'd0, 5'd13);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("flush_no_result", seen, 0);
    run_op(IS_ADD, 32'd7, 32'd8, 32'd0, 32'd0, 5'd14, lat);
    check("post_flush_latency", lat, 1);
    check("post_flush_result", bus.result, 32'd15);
    tick();

    // Same with reset instead of flush
    drive(IS_DIV, 32'hFFFF_FFEC, 32'd3, 32'd0, 32'd0, 5'd15);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstbusy_out_valid", bus.out_valid, 0);
    check("rstbusy_in_ready", bus.in_ready, 1);
    check("rstbusy_result", bus.result, 0);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("rstbusy_no_result", seen, 0);
    run_op(IS_SUB, 32'd30, 32'd8, 32'd0, 32'd0, 5'd16, lat);
    check("post_rst_result", bus.result, 32'd22);
    tick();

    // Op presented with flush is not accepted
    drive(IS_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 5'd17);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_blocks_accept", bus.out_valid, 0);

    // Back-pressure: result held, second op stalled
    bus.out_ready = 1'b0;
    drive(IS_ADD, 32'h11, 32'h22, 32'd0, 32'd0, 5'd18);
    tick();
    drive(IS_SUB, 32'd50, 32'd1, 32'd0, 32'd0, 5'd19);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_result", bus.result, 32'h33);
      check("hold_tag", bus.out_tag, 18);
      check("hold_in_ready", bus.in_ready, 0);
      tick();
    end
    check("hold_result_end", bus.result, 32'h33);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    tick();
    check("release_single", bus.out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
